// File: rtl/idb_arb_pkg.sv
// Shared types and default sizing for the IDB driver-enable arbiter.
package idb_arb_pkg;

  // Default number of requesters / octal driver pairs.
  localparam int ARB_N_DEF          = 4;
  // Default grant cycles before a forced hand-over when others are waiting.
  localparam int ARB_MAX_TENURE_DEF = 8;
  // Default all-drivers-off cycles between two owners.
  localparam int ARB_TURN_DEF       = 1;

  // Width of the tenure counter (MAX_TENURE is at most 255).
  localparam int ARB_TENURE_W = 8;
  // Width of the turnaround counter (TURN is at most 7).
  localparam int ARB_TURN_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/idb_drive_arbiter_rr_pick.sv
// Round-robin picker: first set request after last_owner, wrapping.
// The previous owner is examined last, so it keeps the lowest priority.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic         any,
  output logic [W-1:0] winner
);

  // Walk offsets 1..N from last_owner and keep the first hit.
  always_comb begin
    int         idx;
    logic [W-1:0] idx_w;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int off = 1; off <= N; off++) begin
      idx = int'(last_owner) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_w = idx[W-1:0];
      if (!any && req[idx_w]) begin
        any    = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/idb_drive_arbiter.sv
// Driver-enable arbiter for a shared internal data bus built from octal
// 3-state driver pairs. Grants one pair at a time, round-robin, with a
// bounded tenure and a guaranteed all-off gap between owners.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner, all drivers off, arbitrating every cycle
// ST_GRANT | owner's oe_n low, tenure counting
// ST_TURN  | all drivers off for TURN cycles; arbitrates in final cycle
module idb_drive_arbiter
  import idb_arb_pkg::*;
#(
  parameter int N          = ARB_N_DEF,
  parameter int MAX_TENURE = ARB_MAX_TENURE_DEF,
  parameter int TURN       = ARB_TURN_DEF,
  parameter int W          = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] oe_n,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id,
  output logic         bus_idle
);

  localparam logic [ARB_TENURE_W-1:0] TENURE_MAX = ARB_TENURE_W'(MAX_TENURE);
  localparam logic [ARB_TENURE_W-1:0] TENURE_ONE = ARB_TENURE_W'(1);
  localparam logic [ARB_TURN_W-1:0]   TURN_LOAD  = ARB_TURN_W'(TURN - 1);
  localparam logic [W-1:0]            LAST_RST   = W'(N - 1);
  localparam logic [N-1:0]            ONE_N      = {{(N-1){1'b0}}, 1'b1};

  arb_state_e              state_q, state_d;
  logic [W-1:0]            owner_q, owner_d;
  logic [W-1:0]            last_owner_q, last_owner_d;
  logic [ARB_TENURE_W-1:0] tenure_q, tenure_d;
  logic [ARB_TURN_W-1:0]   turn_cnt_q, turn_cnt_d;

  logic [N-1:0]            oe_n_q, oe_n_d;
  logic                    gnt_valid_q, gnt_valid_d;
  logic [W-1:0]            gnt_id_q, gnt_id_d;
  logic                    bus_idle_q, bus_idle_d;

  logic                    pick_any;
  logic [W-1:0]            pick_winner;
  logic [N-1:0]            owner_mask;
  logic [N-1:0]            owner_next_mask;
  logic                    owner_req;
  logic                    others_req;
  logic                    tenure_full;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  // Decode the current owner's request and whether anyone else is waiting.
  always_comb begin
    owner_mask  = ONE_N << owner_q;
    owner_req   = |(req & owner_mask);
    others_req  = |(req & ~owner_mask);
    tenure_full = (tenure_q == TENURE_MAX);
  end

  // Next-state logic for the IDLE / GRANT / TURNAROUND sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tenure_d     = tenure_q;
    turn_cnt_d   = turn_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_GRANT;
          owner_d  = pick_winner;
          tenure_d = TENURE_ONE;
        end
      end

      ST_GRANT: begin
        // Release and forced hand-over share one exit, so a coincident
        // release and expiry still yields a single turnaround.
        if (!owner_req || (tenure_full && others_req)) begin
          state_d      = ST_TURN;
          last_owner_d = owner_q;
          tenure_d     = '0;
          turn_cnt_d   = TURN_LOAD;
        end else if (tenure_full) begin
          tenure_d = TENURE_ONE;
        end else begin
          tenure_d = tenure_q + TENURE_ONE;
        end
      end

      ST_TURN: begin
        // Requests are only looked at in the last off cycle.
        if (turn_cnt_q == '0) begin
          if (pick_any) begin
            state_d  = ST_GRANT;
            owner_d  = pick_winner;
            tenure_d = TENURE_ONE;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - ARB_TURN_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tenure_d = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from next state and owner so
  // the outputs themselves come straight from flops.
  always_comb begin
    owner_next_mask = ONE_N << owner_d;
    oe_n_d          = '1;
    gnt_valid_d     = 1'b0;
    gnt_id_d        = '0;
    bus_idle_d      = (state_d == ST_IDLE);
    if (state_d == ST_GRANT) begin
      oe_n_d      = ~owner_next_mask;
      gnt_valid_d = 1'b1;
      gnt_id_d    = owner_d;
    end
  end

  // State, owner bookkeeping and registered outputs; reset drops every enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      tenure_q     <= '0;
      turn_cnt_q   <= '0;
      oe_n_q       <= '1;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      bus_idle_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tenure_q     <= tenure_d;
      turn_cnt_q   <= turn_cnt_d;
      oe_n_q       <= oe_n_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_id_q     <= gnt_id_d;
      bus_idle_q   <= bus_idle_d;
    end
  end

  assign oe_n      = oe_n_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_idb_drive_arbiter.sv
// Bench for idb_drive_arbiter: vector table, directed sequences and a
// randomized run against a cycle-level reference model.
module tb_idb_drive_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] oe_n_a, oe_n_b;
  logic       gv_a, gv_b;
  logic [1:0] id_a, id_b;
  logic       idle_a, idle_b;

  idb_drive_arbiter #(.N(4), .MAX_TENURE(8), .TURN(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .oe_n(oe_n_a),
    .gnt_valid(gv_a), .gnt_id(id_a), .bus_idle(idle_a));

  idb_drive_arbiter #(.N(4), .MAX_TENURE(3), .TURN(3)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .oe_n(oe_n_b),
    .gnt_valid(gv_b), .gnt_id(id_b), .bus_idle(idle_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] prev_a = 4'hF;
  logic [3:0] prev_b = 4'hF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle rules: at most one enable low, gnt_valid agrees with it,
  // and no direct hand-over between different owners.
  task automatic check_inv(input string name, input logic [3:0] oe, input logic gv,
                           input logic [3:0] prev);
    logic ok_seq;
    ok_seq = (prev == 4'hF) || (oe == 4'hF) || (prev == oe);
    chk({name, "_onehot"}, 32'($countones(~oe) <= 1), 32'd1);
    chk({name, "_gv_consistent"}, 32'(gv), 32'($countones(~oe) == 1));
    chk({name, "_no_back_to_back"}, 32'(ok_seq), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_inv("a", oe_n_a, gv_a, prev_a);
    check_inv("b", oe_n_b, gv_b, prev_b);
    prev_a = oe_n_a;
    prev_b = oe_n_b;
  endtask

  // ---------------- reference model ----------------
  // owner -1 = nobody; ta = off cycles still to come including this one.
  int m_owner[2], m_ten[2], m_ta[2], m_last[2];
  int m_max[2]  = '{8, 3};
  int m_turn[2] = '{1, 3};

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_step(input int i, input logic rs, input logic [3:0] r);
    int w;
    int others;
    if (rs) begin
      m_owner[i] = -1; m_ten[i] = 0; m_ta[i] = 0; m_last[i] = 3;
    end else if (m_ta[i] > 0) begin
      if (m_ta[i] == 1) begin
        w = pick(r, m_last[i]);
        if (w >= 0) begin m_owner[i] = w; m_ten[i] = 1; end
      end
      m_ta[i] = m_ta[i] - 1;
    end else if (m_owner[i] >= 0) begin
      others = 0;
      for (int b = 0; b < 4; b++) if (b != m_owner[i] && r[b]) others = 1;
      if (!r[m_owner[i]] || (m_ten[i] == m_max[i] && others != 0)) begin
        m_last[i] = m_owner[i]; m_owner[i] = -1; m_ten[i] = 0; m_ta[i] = m_turn[i];
      end else begin
        m_ten[i] = (m_ten[i] == m_max[i]) ? 1 : m_ten[i] + 1;
      end
    end else begin
      w = pick(r, m_last[i]);
      if (w >= 0) begin m_owner[i] = w; m_ten[i] = 1; end
    end
  endtask

  task automatic m_check(input int i, input logic [3:0] oe, input logic gv,
                         input logic [1:0] id, input logic idle);
    logic [3:0] e_oe;
    e_oe = 4'hF;
    if (m_owner[i] >= 0) e_oe[m_owner[i]] = 1'b0;
    chk($sformatf("model%0d_oe_n", i), 32'(oe), 32'(e_oe));
    chk($sformatf("model%0d_gnt_valid", i), 32'(gv), 32'(m_owner[i] >= 0));
    chk($sformatf("model%0d_gnt_id", i), 32'(id), (m_owner[i] >= 0) ? 32'(m_owner[i]) : 32'd0);
    chk($sformatf("model%0d_bus_idle", i), 32'(idle), 32'(m_owner[i] < 0 && m_ta[i] == 0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] oe;
    logic       gv;
    logic [1:0] id;
    logic       idle;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 4'b0001, 4'b1110, 1'b1, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b1110, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 4'b1110, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0001, 4'b1110, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'b0100, 4'b1011, 1'b1, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'b0110, 4'b1011, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{1'b0, 4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 4'b0010, 4'b1101, 1'b1, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 4'b1010, 4'b1101, 1'b1, 2'd1, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
    vecs[15] = '{1'b0, 4'b1111, 4'b1110, 1'b1, 2'd0, 1'b0};

    rst_a = 1'b1; req_a = '0;
    rst_b = 1'b1; req_b = '0;

    // Table: reset, single request, release, round-robin pick, reset mid-grant.
    for (int v = 0; v < 16; v++) begin
      rst_a = vecs[v].rst;
      req_a = vecs[v].req;
      tick();
      chk($sformatf("vec%0d_oe_n", v), 32'(oe_n_a), 32'(vecs[v].oe));
      chk($sformatf("vec%0d_gnt_valid", v), 32'(gv_a), 32'(vecs[v].gv));
      chk($sformatf("vec%0d_gnt_id", v), 32'(id_a), 32'(vecs[v].id));
      chk($sformatf("vec%0d_bus_idle", v), 32'(idle_a), 32'(vecs[v].idle));
    end

    // All four requesting: 8 owned cycles then 1 off cycle per owner, 0,1,2,3,0.
    rst_a = 1'b1; req_a = '0;
    tick(); tick();
    rst_a = 1'b0; req_a = 4'b1111;
    for (int c = 0; c < 45; c++) begin
      logic [3:0] e_oe;
      tick();
      e_oe = 4'hF;
      if (c % 9 < 8) e_oe[(c / 9) % 4] = 1'b0;
      chk($sformatf("rr_full_c%0d_oe_n", c), 32'(oe_n_a), 32'(e_oe));
      if (c % 9 < 8) chk($sformatf("rr_full_c%0d_gnt_id", c), 32'(id_a), 32'((c / 9) % 4));
    end

    // Lone requester keeps the bus with no turnaround across tenure wraps.
    rst_a = 1'b1; req_a = '0;
    tick();
    rst_a = 1'b0; req_a = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk($sformatf("solo_c%0d_oe_n", c), 32'(oe_n_a), 32'(4'b1101));
    end
    rst_a = 1'b1; req_a = '0;

    // TURN=3: owner 2 releases while 3 and 0 wait -> 3 off cycles, then owner 3.
    rst_b = 1'b1; req_b = '0;
    tick();
    rst_b = 1'b0; req_b = 4'b0100;
    tick();
    chk("t3_grant2_id", 32'(id_b), 32'd2);
    tick();
    req_b = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t3_off%0d_oe_n", c), 32'(oe_n_b), 32'(4'b1111));
      chk($sformatf("t3_off%0d_idle", c), 32'(idle_b), 32'd0);
    end
    tick();
    chk("t3_next_oe_n", 32'(oe_n_b), 32'(4'b0111));
    chk("t3_next_gnt_id", 32'(id_b), 32'd3);

    // Randomized run on both instances against the model.
    rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0;
    m_step(0, 1'b1, '0); m_step(1, 1'b1, '0);
    tick();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req_a[b] = ~req_a[b];
        if ($urandom_range(5) == 0) req_b[b] = ~req_b[b];
      end
      if ($urandom_range(63) == 0) req_a = '0;
      if ($urandom_range(63) == 0) req_b = '0;
      rst_a = ($urandom_range(249) == 0);
      rst_b = ($urandom_range(249) == 0);
      m_step(0, rst_a, req_a);
      m_step(1, rst_b, req_b);
      tick();
      m_check(0, oe_n_a, gv_a, id_a, idle_a);
      m_check(1, oe_n_b, gv_b, id_b, idle_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idb_drive_arbiter.md
IDB_DRIVE_ARBITER -- requirements
Module: idb_drive_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the number of requesters and the number of octal 3-state driver pairs controlled (range 2..8).
REQ-002 The module SHALL have parameter MAX_TENURE, default 8, giving the grant cycles before forced hand-over when other requesters are pending (range 2..255).
REQ-003 The module SHALL have parameter TURN, default 1, giving the all-drivers-off cycles between owners (range 1..7).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req, input, N bits: bus request per requester, level-sensitive, held while ownership is wanted.
REQ-007 Port oe_n, output, N bits: active-low output enable per driver pair (G1_n/G2_n tied together); at most one bit low.
REQ-008 Port gnt_valid, output, 1 bit: high when exactly one oe_n bit is low.
REQ-009 Port gnt_id, output, clog2(N) bits: index of the current owner, valid when gnt_valid is high, 0 otherwise.
REQ-010 Port bus_idle, output, 1 bit: high in IDLE state only.

Function
REQ-011 States SHALL be IDLE, GRANT and TURNAROUND; all outputs SHALL be registered (driven from state and owner registers, no combinational path from req).
REQ-012 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod N, wrapping, and selects the first set req bit.
REQ-013 IDLE: if any req bit is high at edge k, the state SHALL become GRANT with oe_n[winner]=0 from edge k+1 (one-cycle latency); otherwise it SHALL remain IDLE.
REQ-014 GRANT: a tenure counter SHALL start at 1 on entry and increment each cycle owned, saturating at MAX_TENURE.
REQ-015 GRANT SHALL go to TURNAROUND when req[owner] is low, or when tenure equals MAX_TENURE and any other req bit is high.
REQ-016 When tenure reaches MAX_TENURE with no other requester pending and req[owner] high, ownership SHALL continue and tenure SHALL reset to 1.
REQ-017 Simultaneous owner release and tenure expiry SHALL cause a single TURNAROUND entry.
REQ-018 On entering TURNAROUND, last_owner SHALL be updated to the owner; all oe_n SHALL be high and gnt_valid low for exactly TURN cycles.
REQ-019 In the final TURNAROUND cycle, if any req bit is high, the state SHALL go directly to GRANT of the round-robin winner; otherwise to IDLE.
REQ-020 The former owner SHALL be eligible in that arbitration, at lowest priority.
REQ-021 Request changes during TURNAROUND before its final cycle SHALL be ignored.
REQ-022 oe_n of two different requesters SHALL never be low in the same cycle, nor in consecutive cycles.

Reset
REQ-023 When rst is high at a clock edge: state IDLE, oe_n all ones, gnt_valid 0, gnt_id 0, bus_idle 1, tenure 0, last_owner N-1 (requester 0 has highest initial priority).
REQ-024 Reset asserted mid-GRANT or mid-TURNAROUND SHALL release all drivers at that edge with no turnaround sequence.
REQ-025 Arbitration SHALL resume on the first edge after rst deasserts.

Structure
REQ-026 The state enumeration and default values of N, MAX_TENURE and TURN SHALL reside in shared package idb_arb_pkg.
REQ-027 Round-robin selection SHALL be a sub-module rr_pick (inputs req and last_owner; outputs any and winner), purely combinational.
REQ-028 No tri-state logic SHALL be inside this block; it drives enables only.

Verification
REQ-029 Reset then req=0001 at cycle 2: oe_n=1110, gnt_id=0 from cycle 3; req=0000 at cycle 6: oe_n=1111 for 1 cycle, then bus_idle=1.
REQ-030 req=1111 held: owners sequence 0,1,2,3,0; each holds 8 cycles followed by 1 all-off cycle.
REQ-031 req=0010 held alone for 30 cycles: oe_n=1101 continuously, no turnaround cycle.
REQ-032 With TURN=3: owner 2 releases while req=1001 pending: 3 all-off cycles, then gnt_id=3.
REQ-033 rst pulsed during GRANT of owner 1: oe_n=1111 on that edge; after release with req=1111, gnt_id=0 first.
REQ-034 A randomized req bench with assertions SHALL check REQ-022 and the one-hot/gnt_valid consistency every cycle.
